// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async FIFO types, defaults and Gray helpers
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Pointers are zero-extended to 32 bits; the upper zeros do not disturb
  // the prefix XOR, so callers cast the result back to their pointer width.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/wfifo_skid_buf.sv
// rtl/wfifo_skid_buf.sv - 2-entry valid/ready skid register feeding the FIFO write port
module wfifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  w_clk,
  input  logic                  w_rstn,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);

  occ_e                  state;
  logic [DATA_WIDTH-1:0] sk_data;
  logic                  accept;
  logic                  commit;

  assign accept = in_valid & in_ready;
  assign commit = out_valid & out_ready;

  // out_valid is its own flop so w_en never sees full or in_valid combinationally.
  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      state     <= OCC_EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sk_data   <= '0;
    end else begin
      in_ready <= 1'b1;
      case (state)
        OCC_EMPTY: begin
          if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept && commit) begin
            out_data <= in_data;
          end else if (accept) begin
            sk_data  <= in_data;
            state    <= OCC_TWO;
            in_ready <= 1'b0;
          end else if (commit) begin
            out_valid <= 1'b0;
            state     <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (commit) begin
            out_data <= sk_data;
            state    <= OCC_ONE;
          end else begin
            in_ready <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= OCC_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/wfifo_ingress.sv
// rtl/wfifo_ingress.sv - write-side front end: skid buffer, fill level and almost-full
module wfifo_ingress
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  w_clk,
  input  logic                  w_rstn,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  w_en,
  output logic [DATA_WIDTH-1:0] w_data,
  input  logic                  full,
  input  logic [ADDR_WIDTH:0]   wptr_gray,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  almost_full
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wbin;
  logic [PW-1:0] rbin;
  logic [PW-1:0] level_next;

  wfifo_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .w_clk    (w_clk),
    .w_rstn   (w_rstn),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(w_en),
    .out_data (w_data),
    .out_ready(~full)
  );

  assign wbin = PW'(gray2bin(32'(wptr_gray)));
  assign rbin = PW'(gray2bin(32'(wq2_rptr)));
  // Modular subtraction absorbs pointer wrap; the stale read pointer only over-reports.
  assign level_next = wbin - rbin;

  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      fill_level  <= '0;
      almost_full <= 1'b0;
    end else begin
      fill_level  <= level_next;
      almost_full <= (level_next >= af_thresh);
    end
  end

endmodule
